tob_publisher: RTL and testbench

Downstream consumer of the order book's top-of-book outputs (best bid/ask price and qty).
- Detects any change in the four TOB words.
- Stamps each change with a sequence number and a cycle timestamp.
- Queues the records and streams each one to the HPS as a 3-beat Avalon-ST packet.
- Sits between the order book and the HPS DMA write path in the 100 MHz domain.

---
 rtl/tob_pub_pkg.sv | 25 ++
 rtl/tob_rec_fifo.sv | 60 ++++++
 rtl/tob_publisher.sv | 155 +++++++++++++++
 tb/tb_tob_publisher.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tob_pub_pkg.sv
// Shared types for the top-of-book publisher: book snapshot, queued record and
// serializer states.
package tob_pub_pkg;

  typedef struct packed {
    logic [31:0] bid_px;
    logic [31:0] bid_qty;
    logic [31:0] ask_px;
    logic [31:0] ask_qty;
  } tob_snap_t;

  typedef struct packed {
    logic [31:0] seq;
    logic [7:0]  flags;
    logic [23:0] ts;
    tob_snap_t   snap;
  } tob_rec_t;

  typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} tob_fsm_e;

  localparam int unsigned FlagCrossed = 0;
  localparam int unsigned FlagLocked  = 1;
  localparam int unsigned RecTsW      = 24;

endpackage

// File: rtl/tob_rec_fifo.sv
// Show-ahead record FIFO: rdata_o is the head entry whenever empty_o is low.
// Depth must be a power of two so the pointers wrap naturally.
module tob_rec_fifo
  import tob_pub_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  tob_rec_t                 wdata_i,
  input  logic                     pop_i,
  output tob_rec_t                 rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  tob_rec_t         mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Full is judged on the registered count, so a same-cycle pop never frees room.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AddrW+1)'(1);
      2'b01:   count_d = count_q - (AddrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tob_publisher.sv
// Stamps every top-of-book change with seq/ts, queues it and streams it as a 3-beat
// Avalon-ST packet. Define TOB_CROSSED_FLAG_EN to fill the crossed/locked flag bits.
module tob_publisher
  import tob_pub_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_W       = 24
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic [31:0] best_bid_px,
  input  logic [31:0] best_bid_qty,
  input  logic [31:0] best_ask_px,
  input  logic [31:0] best_ask_qty,
  input  logic        enable,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_sop,
  output logic        m_eop,
  output logic [2:0]  m_empty,
  output logic [31:0] drop_count
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  tob_snap_t        in_snap, snap_q, prev_q;
  logic             en_q;
  logic [31:0]      seq_q, drop_q;
  logic [TS_W-1:0]  ts_q;
  logic [7:0]       flags;
  logic             change, forced, capture;
  tob_rec_t         push_rec, fifo_rdata, out_q, out_d;
  logic             fifo_full, fifo_empty, pop;
  logic [CntW-1:0]  fifo_count;
  tob_fsm_e         state_q, state_d;

  assign in_snap = {best_bid_px, best_bid_qty, best_ask_px, best_ask_qty};
  assign change  = (snap_q != prev_q);
  assign forced  = enable && !en_q;
  assign capture = enable && (change || forced);

  always_comb begin
    flags = 8'h00;
`ifdef TOB_CROSSED_FLAG_EN
    if (snap_q.bid_qty != '0 && snap_q.ask_qty != '0) begin
      flags[FlagCrossed] = (snap_q.bid_px > snap_q.ask_px);
      flags[FlagLocked]  = (snap_q.bid_px == snap_q.ask_px);
    end
`endif
  end

  assign push_rec = '{seq: seq_q, flags: flags, ts: RecTsW'(ts_q), snap: snap_q};

  // en_q resets high so a reset with enable already high does not force a record of
  // the all-zero snapshot.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
      prev_q <= '0;
      en_q   <= 1'b1;
      seq_q  <= '0;
      ts_q   <= '0;
      drop_q <= '0;
    end else begin
      snap_q <= in_snap;
      prev_q <= snap_q;
      en_q   <= enable;
      ts_q   <= ts_q + TS_W'(1);
      if (capture) begin
        seq_q <= seq_q + 32'd1;
        if (fifo_full && drop_q != '1) drop_q <= drop_q + 32'd1;
      end
    end
  end

  tob_rec_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_100),
    .rst_i   (rst),
    .push_i  (capture),
    .wdata_i (push_rec),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assert property (@(posedge clk_100) disable iff (rst) 32'(fifo_count) <= FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          out_d   = fifo_rdata;
          state_d = StB0;
        end
      end
      StB0: if (m_ready) state_d = StB1;
      StB1: if (m_ready) state_d = StB2;
      StB2: begin
        if (m_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            out_d   = fifo_rdata;
            state_d = StB0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Beats are decoded from registered state only, so they hold under backpressure.
  always_comb begin
    m_data = '0;
    m_sop  = 1'b0;
    m_eop  = 1'b0;
    unique case (state_q)
      StB0: begin
        m_data = {out_q.seq, out_q.flags, out_q.ts};
        m_sop  = 1'b1;
      end
      StB1: m_data = {out_q.snap.bid_px, out_q.snap.bid_qty};
      StB2: begin
        m_data = {out_q.snap.ask_px, out_q.snap.ask_qty};
        m_eop  = 1'b1;
      end
      default: m_data = '0;
    endcase
  end

  assign m_valid    = (state_q != StIdle);
  assign m_empty    = 3'd0;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_tob_publisher.sv
// Randomised and directed bench for tob_publisher against a queue-based record model.
module tb_tob_publisher;

  localparam int unsigned Depth = 4;

`ifdef TOB_CROSSED_FLAG_EN
  localparam bit FlagEn = 1'b1;
`else
  localparam bit FlagEn = 1'b0;
`endif

  logic        clk_100 = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] best_bid_px = '0, best_bid_qty = '0, best_ask_px = '0, best_ask_qty = '0;
  logic        enable = 1'b1;
  logic        m_ready = 1'b1;
  logic        m_valid, m_sop, m_eop;
  logic [63:0] m_data;
  logic [2:0]  m_empty;
  logic [31:0] drop_count;

  always #5 clk_100 = ~clk_100;

  tob_publisher #(
    .FIFO_DEPTH (Depth),
    .TS_W       (24)
  ) dut (
    .clk_100      (clk_100),
    .rst          (rst),
    .best_bid_px  (best_bid_px),
    .best_bid_qty (best_bid_qty),
    .best_ask_px  (best_ask_px),
    .best_ask_qty (best_ask_qty),
    .enable       (enable),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sop        (m_sop),
    .m_eop        (m_eop),
    .m_empty      (m_empty),
    .drop_count   (drop_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: records are {seq, flags, ts, bid_px, bid_qty, ask_px, ask_qty}.
  logic [127:0] m_snap, m_prev;
  logic         m_en;
  logic [31:0]  m_seq, m_drop;
  logic [23:0]  m_ts;
  logic [191:0] m_q[$];
  logic [191:0] m_cur;
  int           m_beat = -1;

  function automatic logic [7:0] model_flags(input logic [127:0] s);
    logic [7:0] f;
    f = 8'h00;
    if (FlagEn && s[95:64] != 0 && s[31:0] != 0) begin
      if (s[127:96] > s[63:32]) f = 8'h01;
      else if (s[127:96] == s[63:32]) f = 8'h02;
    end
    return f;
  endfunction

  function automatic logic [63:0] beat_of(input logic [191:0] r, input int b);
    if (b == 0) return r[191:128];
    if (b == 1) return r[127:64];
    return r[63:0];
  endfunction

  always @(posedge clk_100) begin : model
    int  pre_size;
    bit  accept, popped, cap;
    if (rst) begin
      m_snap = '0; m_prev = '0; m_en = 1'b1; m_seq = '0; m_drop = '0; m_ts = '0;
      m_q.delete(); m_cur = '0; m_beat = -1;
    end else begin
      pre_size = m_q.size();
      accept   = (m_beat >= 0) && m_ready;
      popped   = (pre_size != 0) && (m_beat < 0 || (accept && m_beat == 2));
      cap      = enable && ((m_snap != m_prev) || !m_en);
      if (accept) m_beat = (m_beat == 2) ? -1 : m_beat + 1;
      if (popped) begin
        m_cur  = m_q.pop_front();
        m_beat = 0;
      end
      if (cap) begin
        if (pre_size >= int'(Depth)) begin
          if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
        end else begin
          m_q.push_back({m_seq, model_flags(m_snap), m_ts, m_snap});
        end
        m_seq = m_seq + 1;
      end
      m_prev = m_snap;
      m_snap = {best_bid_px, best_bid_qty, best_ask_px, best_ask_qty};
      m_en   = enable;
      m_ts   = m_ts + 1;
    end
  end

  always @(negedge clk_100) begin
    if (!rst) begin
      check("m_valid", 64'(m_valid), 64'(m_beat >= 0));
      check("drop_count", 64'(drop_count), 64'(m_drop));
      check("m_empty", 64'(m_empty), 64'd0);
      if (m_beat >= 0) begin
        check("m_data", m_data, beat_of(m_cur, m_beat));
        check("m_sop", 64'(m_sop), 64'(m_beat == 0));
        check("m_eop", 64'(m_eop), 64'(m_beat == 2));
      end
    end
  end

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic set_in(input logic [31:0] bp, input logic [31:0] bq,
                        input logic [31:0] ap, input logic [31:0] aq);
    best_bid_px = bp; best_bid_qty = bq; best_ask_px = ap; best_ask_qty = aq;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", m_data, 64'd0);
    check("rst_sop_eop", 64'({m_sop, m_eop}), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: m_valid stayed 0 for %0d cycles, expected 1", max);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    // Single change: latency, literal beats, then idle.
    enable = 1'b1; m_ready = 1'b1;
    do_reset();
    set_in(32'd10000, 32'd5, 32'd10001, 32'd7);
    tick(); check("t1_lat_e1", 64'(m_valid), 64'd0);
    tick(); check("t1_lat_e2", 64'(m_valid), 64'd0);
    tick(); check("t1_lat_e3", 64'(m_valid), 64'd1);
    check("t1_b0", m_data, 64'h0000_0000_0000_0001);
    check("t1_sop", 64'(m_sop), 64'd1);
    tick(); check("t1_b1", m_data, 64'h0000_2710_0000_0005);
    tick(); check("t1_b2", m_data, 64'h0000_2711_0000_0007);
    check("t1_eop", 64'(m_eop), 64'd1);
    tick(); check("t1_idle", 64'(m_valid), 64'd0);
    repeat (10) tick();
    check("t1_still_idle", 64'(m_valid), 64'd0);

    // Backpressure held in B1.
    do_reset();
    set_in(32'h1234, 32'h9, 32'h1240, 32'h3);
    repeat (3) tick();
    check("t2_b0_sop", 64'(m_sop), 64'd1);
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_data", m_data, 64'h0000_1234_0000_0009);
      check("t2_hold_flags", 64'({m_valid, m_sop, m_eop}), 64'b100);
      tick();
    end
    m_ready = 1'b1;
    check("t2_b1_last", m_data, 64'h0000_1234_0000_0009);
    tick(); check("t2_b2", m_data, 64'h0000_1240_0000_0003);
    tick(); check("t2_done", 64'(m_valid), 64'd0);

    // Overflow: one record is held in the output register, four fill the FIFO, so
    // only the sixth of six back-to-back changes is dropped.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_in(32'(1000 + i), 32'd1, 32'd2000, 32'd1);
      tick();
    end
    repeat (3) tick();
    check("t3_drop", 64'(drop_count), 64'd1);
    m_ready = 1'b1;
    repeat (30) tick();
    set_in(32'd3000, 32'd2, 32'd3001, 32'd2);
    wait_valid(10);
    check("t3_next_seq", 64'(m_data[63:32]), 64'd6);

    // Disabled changes are ignored; re-enable forces a resync record.
    do_reset();
    set_in(32'd50, 32'd1, 32'd60, 32'd1);
    repeat (10) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(32'(70 + i), 32'd4, 32'(80 + i), 32'd5);
      repeat (2) tick();
    end
    repeat (8) tick();
    check("t4_no_out", 64'(m_valid), 64'd0);
    enable = 1'b1;
    wait_valid(10);
    check("t4_seq", 64'(m_data[63:32]), 64'd1);
    tick(); check("t4_b1", m_data, 64'h0000_0048_0000_0004);
    repeat (10) tick();

    // Back-to-back changes: six contiguous beats; crossed then locked book.
    do_reset();
    set_in(32'd10005, 32'd1, 32'd10003, 32'd1);
    tick();
    set_in(32'd10003, 32'd1, 32'd10003, 32'd1);
    tick();
    tick();
    for (int j = 0; j < 6; j++) begin
      check("t5_valid", 64'(m_valid), 64'd1);
      check("t5_sop", 64'(m_sop), 64'(j % 3 == 0));
      check("t5_eop", 64'(m_eop), 64'(j % 3 == 2));
      if (j == 0) begin
        check("t5_seq0", 64'(m_data[63:32]), 64'd0);
        check("t6_flags_x", 64'(m_data[31:24]), FlagEn ? 64'h01 : 64'h00);
      end
      if (j == 3) begin
        check("t5_seq1", 64'(m_data[63:32]), 64'd1);
        check("t6_flags_l", 64'(m_data[31:24]), FlagEn ? 64'h02 : 64'h00);
      end
      tick();
    end
    check("t5_done", 64'(m_valid), 64'd0);

    // Reset mid-packet aborts it with no resume.
    set_in(32'd7, 32'd7, 32'd8, 32'd8);
    wait_valid(10);
    do_reset();
    repeat (10) tick();
    check("t7_no_resume", 64'(m_valid), 64'd0);

    // Random traffic, including occasional mid-packet resets.
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(999) < 2) rst = 1'b1;
      if ($urandom_range(99) < 25) begin
        case ($urandom_range(4))
          0: best_bid_px  = 32'(100 + $urandom_range(2));
          1: best_bid_qty = 32'($urandom_range(2));
          2: best_ask_px  = 32'(100 + $urandom_range(2));
          3: best_ask_qty = 32'($urandom_range(2));
          default: best_bid_px = $urandom;
        endcase
      end
      if ($urandom_range(99) < 3) enable = ~enable;
      m_ready = ($urandom_range(99) < 65);
      tick();
    end
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
